// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory,
// with a built-in zero-fill sequence that sweeps every word of the memory.
module mem_arbiter #(
  parameter int  DATA_W    = 32,
  parameter int  MEM_DEPTH = 32,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              last_port1_q, last_port1_d;  // port 1 was granted most recently
  logic [1:0]        rsp_valid_q;
  logic              rsp_read_q;                  // pending response is a read
  logic              clr_done_q, clr_done_d;
  logic [1:0]        grant;

  // Next-state, arbitration and memory-port drive for the current cycle.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_port1_d = last_port1_q;
    clr_done_d   = 1'b0;
    grant        = 2'b00;
    busy         = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          // Clear wins over any pending request in this cycle.
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_port1_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
          endcase

          if (grant[1]) begin
            mem_we    = req_we[1];
            mem_addr  = req_addr[ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[DATA_W +: DATA_W];
          end else if (grant[0]) begin
            mem_we    = req_we[0];
            mem_addr  = req_addr[0 +: ADDR_W];
            mem_wdata = req_wdata[0 +: DATA_W];
          end

          // Pointer moves only when something is actually accepted.
          if (grant != 2'b00) begin
            last_port1_d = grant[1];
          end
        end
      end

      CLEAR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_cnt_q;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, pointer and one-cycle response/completion registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the memory array lives outside this block and is deliberately untouched by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      last_port1_q <= 1'b1;
      rsp_valid_q  <= 2'b00;
      rsp_read_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_port1_q <= last_port1_d;
      rsp_valid_q  <= grant;
      rsp_read_q   <= |(grant & ~req_we);
      clr_done_q   <= clr_done_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign clr_done  = clr_done_q;
  // Memory read data is only forwarded for a read completion; otherwise zero.
  assign rsp_rdata = rsp_read_q ? mem_rdata : '0;

endmodule
